// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fc_pkg
//  Purpose  : Shared types, constants and the output rounding rule for the
//             time-shared fully connected layer sequencer.
//  Contents : fc_state_t (sequencer states), DW, ACCW and fc_out().
//  Revision : 1.0 - initial release
// ============================================================================
package fc_pkg;

    localparam int DW   = 8;    // operand / result width
    localparam int ACCW = 16;   // product and accumulator width

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_BIAS  = 3'd3,
        S_EMIT  = 3'd4
    } fc_state_t;

    // Output neuron value: upper byte of the wrapped 16-bit sum plus the
    // bias, wrapping modulo 256. Matches the combinational layer exactly.
    function automatic logic [DW-1:0] fc_out(
        input logic [ACCW-1:0] acc,
        input logic [DW-1:0]   bias
    );
        return acc[ACCW-1:DW] + bias;
    endfunction

endpackage : fc_pkg
`default_nettype wire

// File: rtl/fc_mac_acc.sv
`default_nettype none
// ============================================================================
//  Module   : fc_mac_acc
//  Purpose  : 8x8 unsigned multiplier feeding a 16-bit wrapping accumulator.
//  Ports    : clk, rst_n  - clock, asynchronous active-low reset
//             clr         - clear accumulator (wins over en)
//             en          - add a*b to the accumulator this cycle
//             a, b        - 8-bit unsigned operands
//             acc         - registered 16-bit accumulator value
//  Revision : 1.0 - initial release
// ============================================================================
module fc_mac_acc
    import fc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [ACCW-1:0] acc
);

    logic [ACCW-1:0] prod;
    logic [ACCW-1:0] acc_d;
    logic [ACCW-1:0] acc_q;

    always_comb begin
        // Full 16-bit product of two 8-bit values never overflows; the sum
        // is allowed to wrap silently.
        prod  = ACCW'(a) * ACCW'(b);
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + prod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule : fc_mac_acc
`default_nettype wire

// File: rtl/fc_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fc_seq_ctrl
//  Purpose  : Sequences one fully connected layer (M outputs, N inputs) on a
//             single time-shared MAC. Streams input/weight/bias buffers with
//             1-cycle read latency and returns each neuron on valid/ready.
//  Ports    : clk, rst_n            - clock, asynchronous active-low reset
//             start, abort          - run request (IDLE only), sync abort
//             busy, done            - activity flag, end-of-layer pulse
//             in_rd_en/in_addr/in_rdata - input vector buffer port
//             w_rd_en/w_addr/w_rdata    - weight matrix buffer (row-major)
//             b_rd_en/b_addr/b_rdata    - bias vector buffer
//             out_valid/out_ready/out_idx/out_data - result stream
//  Revision : 1.0 - initial release
// ============================================================================
module fc_seq_ctrl #(
    parameter int N  = 16,  // input vector length (>= 2)
    parameter int M  = 8,   // output vector length (>= 1)
    parameter int DW = 8    // data width, fixed at 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic                          in_rd_en,
    output logic [$clog2(N)-1:0]          in_addr,
    input  logic [DW-1:0]                 in_rdata,
    output logic                          w_rd_en,
    output logic [$clog2(M*N)-1:0]        w_addr,
    input  logic [DW-1:0]                 w_rdata,
    output logic                          b_rd_en,
    output logic [((M > 1) ? $clog2(M) : 1)-1:0] b_addr,
    input  logic [DW-1:0]                 b_rdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [((M > 1) ? $clog2(M) : 1)-1:0] out_idx,
    output logic [DW-1:0]                 out_data
);

    import fc_pkg::*;

    localparam int NW = $clog2(N);
    localparam int WW = $clog2(M * N);
    localparam int MW = (M > 1) ? $clog2(M) : 1;

    localparam logic [NW-1:0] J_LAST = NW'(N - 1);
    localparam logic [MW-1:0] I_LAST = MW'(M - 1);

    // ------------------------------------------------------------------
    // State, counters and registered outputs
    // ------------------------------------------------------------------
    fc_state_t         state_d,     state_q;
    logic [NW-1:0]     j_d,         j_q;        // column index, drives in_addr
    logic [WW-1:0]     w_d,         w_q;        // running weight address
    logic [MW-1:0]     i_d,         i_q;        // row index, drives b_addr
    logic [DW-1:0]     bias_d,      bias_q;
    logic              busy_d,      busy_q;
    logic              done_d,      done_q;
    logic              rd_en_d,     rd_en_q;    // shared input/weight strobe
    logic              b_rd_en_d,   b_rd_en_q;
    logic              out_valid_d, out_valid_q;
    logic [MW-1:0]     out_idx_d,   out_idx_q;
    logic [DW-1:0]     out_data_d,  out_data_q;

    logic              acc_clr;
    logic              acc_en;
    logic [ACCW-1:0]   acc;

    fc_mac_acc u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (acc_en),
        .a     (in_rdata),
        .b     (w_rdata),
        .acc   (acc)
    );

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        j_d         = j_q;
        w_d         = w_q;
        i_d         = i_q;
        bias_d      = bias_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;

        if (abort) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            acc_clr     = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        i_d     = '0;
                        j_d     = '0;
                        w_d     = '0;
                        acc_clr = 1'b1;
                    end
                end

                S_RUN: begin
                    // Read data lags the strobe by one cycle, so column j
                    // consumes the operands requested at column j-1.
                    acc_en = (j_q != '0);
                    if (j_q == J_LAST) begin
                        state_d = S_DRAIN;
                    end else begin
                        j_d = j_q + 1'b1;
                        w_d = w_q + 1'b1;
                    end
                end

                S_DRAIN: begin
                    acc_en  = 1'b1;
                    bias_d  = b_rdata;
                    state_d = S_BIAS;
                end

                S_BIAS: begin
                    out_data_d  = fc_out(acc, bias_q);
                    out_idx_d   = i_q;
                    out_valid_d = 1'b1;
                    state_d     = S_EMIT;
                end

                S_EMIT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (i_q == I_LAST) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            // Weight address simply continues into the next
                            // row: row-major layout makes i*N+j contiguous.
                            i_d     = i_q + 1'b1;
                            j_d     = '0;
                            w_d     = w_q + 1'b1;
                            acc_clr = 1'b1;
                            state_d = S_RUN;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Strobes are registered from the next state so they line up with
        // the cycle in which the sequencer sits in RUN.
        busy_d    = (state_d != S_IDLE);
        rd_en_d   = (state_d == S_RUN);
        b_rd_en_d = rd_en_d && (j_d == J_LAST);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            j_q         <= '0;
            w_q         <= '0;
            i_q         <= '0;
            bias_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            b_rd_en_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            j_q         <= j_d;
            w_q         <= w_d;
            i_q         <= i_d;
            bias_q      <= bias_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            b_rd_en_q   <= b_rd_en_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy      = busy_q;
    assign done      = done_q;
    assign in_rd_en  = rd_en_q;
    assign w_rd_en   = rd_en_q;
    assign b_rd_en   = b_rd_en_q;
    assign in_addr   = j_q;
    assign w_addr    = w_q;
    assign b_addr    = i_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;

endmodule : fc_seq_ctrl
`default_nettype wire

// File: tb/tb_fc_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fc_seq_ctrl
//  Purpose  : Self-checking bench for fc_seq_ctrl (N=4, M=3) with buffer
//             models and an arithmetic reference of the layer.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fc_seq_ctrl;

    localparam int N  = 4;
    localparam int M  = 3;
    localparam int NW = $clog2(N);
    localparam int WW = $clog2(M * N);
    localparam int MW = (M > 1) ? $clog2(M) : 1;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, done, in_rd_en, w_rd_en, b_rd_en, out_valid;
    logic [NW-1:0] in_addr;
    logic [WW-1:0] w_addr;
    logic [MW-1:0] b_addr, out_idx;
    logic [7:0]    in_rdata = 8'd0;
    logic [7:0]    w_rdata  = 8'd0;
    logic [7:0]    b_rdata  = 8'd0;
    logic [7:0]    out_data;

    logic [7:0]    in_mem [N];
    logic [7:0]    w_mem  [M*N];
    logic [7:0]    b_mem  [M];
    int            exp_data [M];

    int            wq[$];
    int            iq[$];
    int            bq[$];
    int            b_pos_err = 0;
    int            pair_err  = 0;

    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    fc_seq_ctrl #(.N(N), .M(M), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .in_rd_en  (in_rd_en),
        .in_addr   (in_addr),
        .in_rdata  (in_rdata),
        .w_rd_en   (w_rd_en),
        .w_addr    (w_addr),
        .w_rdata   (w_rdata),
        .b_rd_en   (b_rd_en),
        .b_addr    (b_addr),
        .b_rdata   (b_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data)
    );

    // Synchronous-read buffers, 1-cycle latency, with a read log.
    always @(posedge clk) begin
        if (in_rd_en !== w_rd_en) pair_err++;
        if (in_rd_en) begin
            in_rdata <= in_mem[in_addr];
            iq.push_back(int'(in_addr));
        end
        if (w_rd_en) begin
            w_rdata <= w_mem[w_addr];
            wq.push_back(int'(w_addr));
        end
        if (b_rd_en) begin
            b_rdata <= b_mem[b_addr];
            bq.push_back(int'(b_addr));
            if (int'(in_addr) != N - 1) b_pos_err++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({busy, done, in_rd_en, w_rd_en, b_rd_en, out_valid,
                    in_addr, w_addr, b_addr, out_idx, out_data});
    endfunction

    task automatic set_const(input int iv, input int wv, input int bv, input int ev);
        for (int k = 0; k < N; k++)     in_mem[k] = 8'(iv);
        for (int k = 0; k < M * N; k++) w_mem[k]  = 8'(wv);
        for (int k = 0; k < M; k++) begin
            b_mem[k]    = 8'(bv);
            exp_data[k] = ev;
        end
    endtask

    // Reference: out_i = ((sum_j x_j*w_ij mod 2^16) div 256 + b_i) mod 256.
    task automatic set_random();
        int sum;
        for (int k = 0; k < N; k++)     in_mem[k] = 8'($urandom_range(0, 255));
        for (int k = 0; k < M * N; k++) w_mem[k]  = 8'($urandom_range(0, 255));
        for (int k = 0; k < M; k++)     b_mem[k]  = 8'($urandom_range(0, 255));
        for (int r = 0; r < M; r++) begin
            sum = 0;
            for (int c = 0; c < N; c++) sum += int'(in_mem[c]) * int'(w_mem[r*N + c]);
            sum = sum % 65536;
            exp_data[r] = ((sum / 256) + int'(b_mem[r])) % 256;
        end
    endtask

    // mode: 0 = ready always high, 1 = random ready, 2 = hold ready low for
    // 10 valid cycles on the first row. chained: start already raised by
    // the previous run's done cycle. chain_out: raise start in the done
    // cycle. poke: pulse start while busy.
    task automatic run_layer(input int mode, input bit chained, input bit chain_out, input bit poke);
        int cyc, got, stall, bad_rd, bad_hold, done_bad, first_cyc, h_cyc, addr_err;
        bit prev_v, nxt;
        logic [7:0]    prev_data;
        logic [MW-1:0] prev_idx;

        wq.delete(); iq.delete(); bq.delete();
        b_pos_err = 0; pair_err = 0;
        if (!chained) begin
            @(posedge clk); #1 start = 1'b1;
        end
        @(posedge clk); #1 start = 1'b0;

        cyc = 1; got = 0; stall = 0; bad_rd = 0; bad_hold = 0; done_bad = 0;
        first_cyc = -1; h_cyc = -1; prev_v = 1'b0; nxt = 1'b0;
        prev_data = '0; prev_idx = '0;
        while (got < M && cyc < 400) begin
            @(negedge clk);
            if (poke) start = (cyc == 2 || cyc == N + 3);
            if (nxt) begin
                chk("row_restart_rd", 32'({in_rd_en, w_rd_en}), 32'd3);
                chk("row_restart_in_addr", 32'(in_addr), 32'd0);
                nxt = 1'b0;
            end
            if (done) done_bad++;
            if (out_valid && (in_rd_en || w_rd_en || b_rd_en)) bad_rd++;
            if (prev_v && (!out_valid || out_data !== prev_data || out_idx !== prev_idx)) bad_hold++;
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = 1'($urandom_range(0, 1));
                    default: begin
                        out_ready = (stall >= 10);
                        stall++;
                    end
                endcase
                if (out_ready) begin
                    chk("out_idx", 32'(out_idx), got);
                    chk("out_data", 32'(out_data), exp_data[got]);
                    got++;
                    h_cyc = cyc;
                    nxt = (got < M);
                end
            end else begin
                out_ready = 1'b0;
            end
            prev_v    = out_valid && !out_ready;
            prev_data = out_data;
            prev_idx  = out_idx;
            cyc++;
        end
        chk("handshakes", got, M);
        start = 1'b0;

        if (chain_out) begin
            @(posedge clk); #1 start = 1'b1;
        end
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        out_ready = 1'b0;
        if (!chain_out) begin
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'd0);
        end

        chk("first_valid_cycle", first_cyc, N + 3);
        chk("no_reads_while_valid", bad_rd, 0);
        chk("emit_hold_stable", bad_hold, 0);
        chk("no_early_done", done_bad, 0);
        if (mode == 0) chk("layer_cycles", h_cyc, M * (N + 3));
        if (mode == 2) chk("stall_length", stall, 11 + (M - 1));

        addr_err = 0;
        if (wq.size() != M * N || iq.size() != M * N || bq.size() != M) begin
            addr_err++;
        end else begin
            for (int k = 0; k < M * N; k++) begin
                if (wq[k] != k)     addr_err++;
                if (iq[k] != k % N) addr_err++;
            end
            for (int k = 0; k < M; k++) if (bq[k] != k) addr_err++;
        end
        chk("w_read_count", wq.size(), M * N);
        chk("read_addr_sequence", addr_err, 0);
        chk("b_read_on_last_j", b_pos_err, 0);
        chk("in_w_strobe_pair", pair_err, 0);
    endtask

    task automatic abort_test();
        int bad;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_at_j2", 32'({in_rd_en, 2'(in_addr)}), 32'h6);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_next", 32'({busy, out_valid, in_rd_en, w_rd_en, b_rd_en, done}), 32'd0);
        bad = 0;
        repeat (3 * (N + 3)) begin
            @(negedge clk);
            if (done || out_valid || busy) bad++;
        end
        chk("abort_stays_idle", bad, 0);
    endtask

    task automatic reset_test();
        int cyc;
        out_ready = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("reset_reach_emit", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_async_zero", all_outs(), 32'd0);
        @(posedge clk); #1;
        chk("reset_held_zero", all_outs(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_release_idle", all_outs(), 32'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;

        // 16*16*4 = 0x0400 -> 0x04 + 3
        set_const(16, 16, 3, 8'h07);
        run_layer(0, 1'b0, 1'b0, 1'b0);

        // 4*65025 mod 65536 = 0xF804 -> 0xF8
        set_const(255, 255, 0, 8'hF8);
        run_layer(0, 1'b0, 1'b0, 1'b0);

        // 0xF8 + 0x10 wraps to 0x08; backpressure on the first row
        set_const(255, 255, 16, 8'h08);
        run_layer(2, 1'b0, 1'b0, 1'b0);

        // Random data, random ready, start pokes while busy, restart in done cycle
        set_random();
        run_layer(1, 1'b0, 1'b1, 1'b1);
        set_random();
        run_layer(0, 1'b1, 1'b0, 1'b0);

        abort_test();
        set_random();
        run_layer(0, 1'b0, 1'b0, 1'b0);

        reset_test();
        set_random();
        run_layer(1, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fc_seq_ctrl
`default_nettype wire
